// File: rtl/norm_mult_pkg.sv
// Shared definitions for the normalise-multiply-denormalise controller:
// FSM state encodings and the shift-counter width helper.
package norm_mult_pkg;

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] WAIT   = 4'd1;
  localparam logic [3:0] LOAD   = 4'd2;
  localparam logic [3:0] NORMA  = 4'd3;
  localparam logic [3:0] NORMB  = 4'd4;
  localparam logic [3:0] MULT   = 4'd5;
  localparam logic [3:0] DENORM = 4'd6;
  localparam logic [3:0] DONE   = 4'd7;
  localparam logic [3:0] ZERO   = 4'd8;

  // Counter must hold the largest combined shift, 2*(width-1).
  function automatic int cnt_width(input int width);
    return $clog2(2 * width - 1);
  endfunction

endpackage

// File: rtl/norm_mult_ctrl_counter.sv
// Up/down shift counter. Clear wins over up and down. A decrement at zero is
// ignored, so the count never wraps below zero.
module shift_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             up,
  input  logic             dn,
  output logic [CNT_W-1:0] q,
  output logic             isZero
);

  // Count register: clear, else increment, else decrement if nonzero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (up) begin
      q <= q + CNT_W'(1);
    end else if (dn && (q != '0)) begin
      q <= q - CNT_W'(1);
    end
  end

  assign isZero = (q == '0);

endmodule

// File: rtl/norm_mult_ctrl.sv
// Control FSM for the normalise-multiply-denormalise datapath. Normalises A,
// then B, by left shifts. It counts the shifts, fires the product load, then
// shifts the product right by the same total. A zero operand skips straight
// to a done/zero_out pulse.
module norm_mult_ctrl
  import norm_mult_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             msbA,
  input  logic             msbB,
  input  logic             zeroA,
  input  logic             zeroB,
  output logic             busy,
  output logic             done,
  output logic             zero_out,
  output logic             loadA,
  output logic             loadB,
  output logic             shlA,
  output logic             shlB,
  output logic             loadOut,
  output logic             shrOut,
  output logic [CNT_W-1:0] shift_cnt
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(2 * (WIDTH - 1));

  logic [3:0] state;
  logic [3:0] nextState;
  logic       cntClr;
  logic       cntUp;
  logic       cntDn;
  logic       cntIsZero;
  logic       anyZero;

  assign anyZero = zeroA | zeroB;

  shift_counter #(.CNT_W(CNT_W)) uCounter (
    .clk    (clk),
    .rst    (rst),
    .clr    (cntClr),
    .up     (cntUp),
    .dn     (cntDn),
    .q      (shift_cnt),
    .isZero (cntIsZero)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic. The operation launches on the falling edge of start.
  always_comb begin
    nextState = IDLE;
    case (state)
      IDLE:   nextState = start ? WAIT : IDLE;
      WAIT:   nextState = start ? WAIT : LOAD;
      LOAD:   nextState = NORMA;
      NORMA:  nextState = anyZero ? ZERO : (msbA ? NORMB : NORMA);
      NORMB:  nextState = msbB ? MULT : NORMB;
      MULT:   nextState = DENORM;
      DENORM: nextState = cntIsZero ? DONE : DENORM;
      DONE:   nextState = IDLE;
      ZERO:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output decode from state and datapath status flags.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    zero_out = 1'b0;
    loadA    = 1'b0;
    loadB    = 1'b0;
    shlA     = 1'b0;
    shlB     = 1'b0;
    loadOut  = 1'b0;
    shrOut   = 1'b0;
    cntClr   = 1'b0;
    case (state)
      LOAD: begin
        busy   = 1'b1;
        loadA  = 1'b1;
        loadB  = 1'b1;
        cntClr = 1'b1;
      end
      NORMA: begin
        busy = 1'b1;
        shlA = !anyZero && !msbA;
      end
      NORMB: begin
        busy = 1'b1;
        shlB = !msbB;
      end
      MULT: begin
        busy    = 1'b1;
        loadOut = 1'b1;
      end
      DENORM: begin
        busy   = 1'b1;
        shrOut = !cntIsZero;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      ZERO: begin
        busy     = 1'b1;
        done     = 1'b1;
        zero_out = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign cntUp = shlA | shlB;
  assign cntDn = shrOut;

  // The accumulated shift can never exceed the two operands' worst case.
  cntBound: assert property (@(posedge clk) disable iff (!rst) shift_cnt <= MAX_CNT);

endmodule

// File: tb/tb_norm_mult_ctrl.sv
// Self-checking bench for norm_mult_ctrl at WIDTH=8. A small datapath model
// (A/B shift registers) feeds the status flags back to the controller. Each
// operation is measured and compared with closed-form latency/shift-count
// expectations derived from the operands' leading-zero counts.
module tb_norm_mult_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  typedef struct {
    int shlA;
    int shlB;
    int shr;
    int peak;
    int loadOutCyc;
    int doneCyc;
    int zero;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] aIn = '0;
  logic [WIDTH-1:0] bIn = '0;
  logic [WIDTH-1:0] aReg = '0;
  logic [WIDTH-1:0] bReg = '0;
  logic             msbA, msbB, zeroA, zeroB;
  logic             busy, done, zero_out, loadA, loadB, shlA, shlB, loadOut, shrOut;
  logic [CNT_W-1:0] shift_cnt;

  int checks = 0;
  int errors = 0;

  int mFirstLoad, mShlA, mShlB, mShr, mPeak, mLoadOutCyc, mDoneCyc;
  int mZeroAtDone, mBusyCnt, mDoneCnt;

  norm_mult_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .msbA      (msbA),
    .msbB      (msbB),
    .zeroA     (zeroA),
    .zeroB     (zeroB),
    .busy      (busy),
    .done      (done),
    .zero_out  (zero_out),
    .loadA     (loadA),
    .loadB     (loadB),
    .shlA      (shlA),
    .shlB      (shlB),
    .loadOut   (loadOut),
    .shrOut    (shrOut),
    .shift_cnt (shift_cnt)
  );

  always #5 clk = ~clk;

  // Datapath model: operand registers driven by the controller's commands.
  always @(posedge clk) begin
    if (loadA) aReg <= aIn;
    else if (shlA) aReg <= aReg << 1;
    if (loadB) bReg <= bIn;
    else if (shlB) bReg <= bReg << 1;
  end

  assign msbA  = aReg[WIDTH-1];
  assign msbB  = bReg[WIDTH-1];
  assign zeroA = (aReg == '0);
  assign zeroB = (bReg == '0);

  // Reference: shifts to normalise x = (WIDTH-1) - floor(log2 x).
  function automatic int lzc(input int x);
    return (WIDTH - 1) - ($clog2(x + 1) - 1);
  endfunction

  function automatic exp_t refModel(input int a, input int b);
    exp_t e;
    if (a == 0 || b == 0) begin
      e = '{shlA: 0, shlB: 0, shr: 0, peak: 0, loadOutCyc: 0, doneCyc: 3, zero: 1};
    end else begin
      e.shlA = lzc(a);
      e.shlB = lzc(b);
      e.shr = e.shlA + e.shlB;
      e.peak = e.shlA + e.shlB;
      e.loadOutCyc = e.shlA + e.shlB + 4;
      e.doneCyc = 2 * (e.shlA + e.shlB) + 6;
      e.zero = 0;
    end
    return e;
  endfunction

  // Start pulse: one cycle high, then low; next cycle should be LOAD.
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    aIn = a;
    bIn = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observe one operation from LOAD (cycle 1) until done, bounded.
  task automatic measure(input int pulseAt);
    mFirstLoad = 0; mShlA = 0; mShlB = 0; mShr = 0; mPeak = 0;
    mLoadOutCyc = 0; mDoneCyc = 0; mZeroAtDone = 0; mBusyCnt = 0; mDoneCnt = 0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (cyc == 1) mFirstLoad = int'(loadA && loadB);
      mShlA += int'(shlA);
      mShlB += int'(shlB);
      mShr += int'(shrOut);
      if (cyc >= 2 && int'(shift_cnt) > mPeak) mPeak = int'(shift_cnt);
      if (loadOut) mLoadOutCyc = cyc;
      mBusyCnt += int'(busy);
      if (cyc == pulseAt) start = 1'b1;
      if (cyc == pulseAt + 1) start = 1'b0;
      if (done) begin
        mDoneCnt++;
        mDoneCyc = cyc;
        mZeroAtDone = int'(zero_out);
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, zero_out, loadA, loadB, shlA, shlB, loadOut, shrOut} !== 9'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 0", {busy, done, zero_out, loadA, loadB, shlA, shlB, loadOut, shrOut});
    end
    checks++;
    if (shift_cnt !== '0) begin
      errors++;
      $display("[TB] FAIL reset_cnt: got %0d expected 0", shift_cnt);
    end
    rst = 1'b1;
  endtask

  task automatic test_directed;
    launch(8'h01, 8'h80);
    measure(0);
    checks++; if (mShlA !== 7) begin errors++; $display("[TB] FAIL d1_shlA: got %0d expected 7", mShlA); end
    checks++; if (mShlB !== 0) begin errors++; $display("[TB] FAIL d1_shlB: got %0d expected 0", mShlB); end
    checks++; if (mPeak !== 7) begin errors++; $display("[TB] FAIL d1_peak: got %0d expected 7", mPeak); end
    checks++; if (mShr !== 7) begin errors++; $display("[TB] FAIL d1_shr: got %0d expected 7", mShr); end
    checks++; if (mDoneCyc !== 20) begin errors++; $display("[TB] FAIL d1_done: got %0d expected 20", mDoneCyc); end

    launch(8'h80, 8'h80);
    measure(0);
    checks++; if (mShlA + mShlB !== 0) begin errors++; $display("[TB] FAIL d2_shl: got %0d expected 0", mShlA + mShlB); end
    checks++; if (mLoadOutCyc !== 4) begin errors++; $display("[TB] FAIL d2_loadOut: got %0d expected 4", mLoadOutCyc); end
    checks++; if (mShr !== 0) begin errors++; $display("[TB] FAIL d2_shr: got %0d expected 0", mShr); end
    checks++; if (mDoneCyc !== 6) begin errors++; $display("[TB] FAIL d2_done: got %0d expected 6", mDoneCyc); end

    launch(8'h00, 8'h35);
    measure(0);
    checks++; if (mDoneCyc !== 3) begin errors++; $display("[TB] FAIL d3_done: got %0d expected 3", mDoneCyc); end
    checks++; if (mZeroAtDone !== 1) begin errors++; $display("[TB] FAIL d3_zero: got %0d expected 1", mZeroAtDone); end
    checks++; if (mLoadOutCyc !== 0 || mShr !== 0) begin
      errors++; $display("[TB] FAIL d3_noMult: got loadOut %0d shr %0d expected 0 0", mLoadOutCyc, mShr);
    end
  endtask

  task automatic test_start_held;
    int heldBad;
    heldBad = 0;
    @(negedge clk);
    aIn = 8'h10;
    bIn = 8'h10;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy || loadA) heldBad++;
    end
    checks++;
    if (heldBad !== 0) begin errors++; $display("[TB] FAIL held_idle: got %0d busy cycles expected 0", heldBad); end
    start = 1'b0;
    measure(0);
    checks++; if (mFirstLoad !== 1) begin errors++; $display("[TB] FAIL held_load: got %0d expected 1", mFirstLoad); end
    checks++; if (mDoneCyc !== 18) begin errors++; $display("[TB] FAIL held_done: got %0d expected 18", mDoneCyc); end
  endtask

  task automatic test_reset_midop;
    int found, doneSeen;
    found = 0;
    doneSeen = 0;
    launch(8'h08, 8'h80);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (shrOut && shift_cnt == 4'd4) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (found !== 1) begin errors++; $display("[TB] FAIL mid_reach: got %0d expected 1", found); end
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, zero_out, loadA, loadB, shlA, shlB, loadOut, shrOut} !== 9'b0) begin
      errors++;
      $display("[TB] FAIL mid_outputs: got %b expected 0", {busy, done, zero_out, loadA, loadB, shlA, shlB, loadOut, shrOut});
    end
    checks++;
    if (shift_cnt !== '0) begin errors++; $display("[TB] FAIL mid_cnt: got %0d expected 0", shift_cnt); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checks++;
    if (doneSeen !== 0) begin errors++; $display("[TB] FAIL mid_noDone: got %0d expected 0", doneSeen); end
    launch(8'h20, 8'h40);
    measure(0);
    checks++; if (mDoneCyc !== 12) begin errors++; $display("[TB] FAIL mid_rerun: got %0d expected 12", mDoneCyc); end
  endtask

  task automatic test_back_to_back;
    int idleBad;
    idleBad = 0;
    launch(8'h40, 8'hC0);
    measure(0);
    checks++; if (mDoneCyc !== 8) begin errors++; $display("[TB] FAIL b2b_first: got %0d expected 8", mDoneCyc); end
    aIn = 8'h03;
    bIn = 8'h81;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    measure(3);
    checks++; if (mFirstLoad !== 1) begin errors++; $display("[TB] FAIL b2b_load: got %0d expected 1", mFirstLoad); end
    checks++; if (mDoneCyc !== 18) begin errors++; $display("[TB] FAIL b2b_done: got %0d expected 18", mDoneCyc); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy || loadA) idleBad++;
    end
    checks++;
    if (idleBad !== 0) begin errors++; $display("[TB] FAIL b2b_ignore: got %0d busy cycles expected 0", idleBad); end
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] a, b;
    exp_t e;
    for (int n = 0; n < 24; n++) begin
      a = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      e = refModel(int'(a), int'(b));
      launch(a, b);
      measure(0);
      checks++;
      if (mDoneCyc !== e.doneCyc) begin
        errors++; $display("[TB] FAIL rnd_done a=%h b=%h: got %0d expected %0d", a, b, mDoneCyc, e.doneCyc);
      end
      checks++;
      if (mShlA !== e.shlA || mShlB !== e.shlB) begin
        errors++; $display("[TB] FAIL rnd_shl a=%h b=%h: got %0d/%0d expected %0d/%0d", a, b, mShlA, mShlB, e.shlA, e.shlB);
      end
      checks++;
      if (mShr !== e.shr || mPeak !== e.peak) begin
        errors++; $display("[TB] FAIL rnd_shr a=%h b=%h: got %0d/%0d expected %0d/%0d", a, b, mShr, mPeak, e.shr, e.peak);
      end
      checks++;
      if (mLoadOutCyc !== e.loadOutCyc || mZeroAtDone !== e.zero) begin
        errors++; $display("[TB] FAIL rnd_mult a=%h b=%h: got %0d/%0d expected %0d/%0d", a, b, mLoadOutCyc, mZeroAtDone, e.loadOutCyc, e.zero);
      end
      checks++;
      if (mBusyCnt !== e.doneCyc) begin
        errors++; $display("[TB] FAIL rnd_busy a=%h b=%h: got %0d expected %0d", a, b, mBusyCnt, e.doneCyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_held();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
